// File: rtl/modular_inverse.sv
// Binary extended-Euclid modular inverse: b_out * a_in == 1 (mod base), base odd.
// Build option: define MODULAR_INVERSE_REDUCE_EN to reduce a_in mod base first (any a_in legal).
module modular_inverse #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] base,
    input  logic             valid_in,
    output logic [WIDTH-1:0] b_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             error_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, REDUCE, HALVE, SUB, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m_r, m_nxt;
    logic [WIDTH-1:0] u, u_nxt, v, v_nxt;
    logic [WIDTH-1:0] x1, x1_nxt, x2, x2_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic             valid_nxt, busy_nxt, err_nxt;
`ifdef MODULAR_INVERSE_REDUCE_EN
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH:0]   rem;
`endif

    // x/2 mod m for odd m, with a one-bit-wider sum so x+m cannot overflow
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        return (x >= y) ? (x - y) : (x - y + m);
    endfunction

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            m_r       <= '0;
            u         <= '0;
            v         <= '0;
            x1        <= '0;
            x2        <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
            error_out <= 1'b0;
`ifdef MODULAR_INVERSE_REDUCE_EN
            a_r       <= '0;
            cnt       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            m_r       <= m_nxt;
            u         <= u_nxt;
            v         <= v_nxt;
            x1        <= x1_nxt;
            x2        <= x2_nxt;
            b_out     <= b_nxt;
            valid_out <= valid_nxt;
            busy_out  <= busy_nxt;
            error_out <= err_nxt;
`ifdef MODULAR_INVERSE_REDUCE_EN
            a_r       <= a_nxt;
            cnt       <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m_r;
        u_nxt     = u;
        v_nxt     = v;
        x1_nxt    = x1;
        x2_nxt    = x2;
        b_nxt     = b_out;
        err_nxt   = error_out;
`ifdef MODULAR_INVERSE_REDUCE_EN
        a_nxt     = a_r;
        cnt_nxt   = cnt;
        rem       = '0;
`endif
        case (state)
            IDLE: begin
                if (valid_in) begin
                    m_nxt   = base;
                    err_nxt = 1'b0;
                    if (!base[0] || base < WIDTH'(3)) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                        b_nxt     = '0;
                    end else begin
`ifdef MODULAR_INVERSE_REDUCE_EN
                        a_nxt     = a_in;
                        u_nxt     = '0;
                        cnt_nxt   = '0;
                        state_nxt = REDUCE;
`else
                        if (a_in >= base || a_in == '0) begin
                            state_nxt = DONE;
                            err_nxt   = 1'b1;
                            b_nxt     = '0;
                        end else begin
                            u_nxt     = a_in;
                            v_nxt     = base;
                            x1_nxt    = WIDTH'(1);
                            x2_nxt    = '0;
                            state_nxt = HALVE;
                        end
`endif
                    end
                end
            end
`ifdef MODULAR_INVERSE_REDUCE_EN
            // restoring division, MSB of a first; u holds the running remainder
            REDUCE: begin
                rem = {u, a_r[WIDTH-1]};
                if (rem >= {1'b0, m_r}) rem = rem - {1'b0, m_r};
                u_nxt   = rem[WIDTH-1:0];
                a_nxt   = a_r << 1;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    if (rem[WIDTH-1:0] == '0) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                        b_nxt     = '0;
                    end else begin
                        v_nxt     = m_r;
                        x1_nxt    = WIDTH'(1);
                        x2_nxt    = '0;
                        state_nxt = HALVE;
                    end
                end
            end
`endif
            HALVE: begin
                if (u == WIDTH'(1)) begin
                    state_nxt = DONE;
                    b_nxt     = x1;
                end else if (v == WIDTH'(1)) begin
                    state_nxt = DONE;
                    b_nxt     = x2;
                end else if (u == '0 || v == '0) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                    b_nxt     = '0;
                end else if (!u[0]) begin
                    u_nxt  = u >> 1;
                    x1_nxt = half_mod(x1, m_r);
                end else if (!v[0]) begin
                    v_nxt  = v >> 1;
                    x2_nxt = half_mod(x2, m_r);
                end else begin
                    state_nxt = SUB;
                end
            end
            // odd minus odd is always even, so the first halving is folded in here
            SUB: begin
                if (u >= v) begin
                    u_nxt  = (u - v) >> 1;
                    x1_nxt = half_mod(sub_mod(x1, x2, m_r), m_r);
                end else begin
                    v_nxt  = (v - u) >> 1;
                    x2_nxt = half_mod(sub_mod(x2, x1, m_r), m_r);
                end
                state_nxt = HALVE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        valid_nxt = (state_nxt == DONE);
        busy_nxt  = (state_nxt inside {REDUCE, HALVE, SUB});
    end

endmodule

// File: tb/tb_modular_inverse.sv
// Directed bench for modular_inverse with a scoreboard queue of expected results.
// Expectations follow MODULAR_INVERSE_REDUCE_EN when it is defined for the build.
module tb_modular_inverse;

    localparam int unsigned WIDTH = 512;
`ifdef MODULAR_INVERSE_REDUCE_EN
    localparam bit RED = 1'b1;
    localparam int LAT_MAX = 4 * WIDTH + 8;
`else
    localparam bit RED = 1'b0;
    localparam int LAT_MAX = 3 * WIDTH + 8;
`endif

    localparam logic [WIDTH-1:0] BIG_A = 512'd11771277631567105112429390968344039472017655878094069789596899075379556637591777263612685912638072676971202571005125788549738055042212111622006381650085741;
    localparam logic [WIDTH-1:0] BIG_M = 512'd7038747235645766647601534062230126447880082574479551592729267315028956456991270137047483167243727743721697091099593982762286861266825761539834903570699207;
    localparam logic [WIDTH-1:0] BIG_B = 512'd3026486573922135933347162266434197347000801954591955628451452122615628358378622438321873052256261617382380550515818316432815442076960637096436427767588780;

    typedef struct {
        logic [WIDTH-1:0] b;
        logic             err;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] base;
    logic             valid_in;
    logic [WIDTH-1:0] b_out;
    logic             valid_out;
    logic             busy_out;
    logic             error_out;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    modular_inverse #(.WIDTH(WIDTH)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .a_in      (a_in),
        .base      (base),
        .valid_in  (valid_in),
        .b_out     (b_out),
        .valid_out (valid_out),
        .busy_out  (busy_out),
        .error_out (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one start strobe and queue its expected result; returns one negedge after acceptance
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m,
                         input logic [WIDTH-1:0] eb, input logic ee);
        exp_t e;
        e.b   = eb;
        e.err = ee;
        @(negedge clk_in);
        a_in     = a;
        base     = m;
        valid_in = 1'b1;
        sb.push_back(e);
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    // cyc0 = cycles already elapsed since the accepting edge plus one
    task automatic wait_done(input string tag, input int cyc0);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc <= LAT_MAX + 4) begin
            if (valid_out === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk_in);
                cyc++;
            end
        end
        check({tag, "_seen"}, WIDTH'(seen), WIDTH'(1));
        if (!seen) begin
            sb.delete();
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected"}, WIDTH'(1), WIDTH'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_b"}, b_out, e.b);
            check({tag, "_err"}, WIDTH'(error_out), WIDTH'(e.err));
            check({tag, "_busy_in_done"}, WIDTH'(busy_out), WIDTH'(0));
            check({tag, "_latency"}, WIDTH'(cyc - 1 <= LAT_MAX), WIDTH'(1));
            @(negedge clk_in);
            check({tag, "_pulse_one_cycle"}, WIDTH'(valid_out), WIDTH'(0));
            check({tag, "_b_hold"}, b_out, e.b);
            check({tag, "_err_hold"}, WIDTH'(error_out), WIDTH'(e.err));
        end
    endtask

    initial begin
        int pulses;
        rst_in   = 1'b0;
        a_in     = '0;
        base     = '0;
        valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        // valid_in during reset must be ignored
        a_in     = WIDTH'(3);
        base     = WIDTH'(7);
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        check("rst_b", b_out, '0);
        check("rst_valid", WIDTH'(valid_out), WIDTH'(0));
        check("rst_busy", WIDTH'(busy_out), WIDTH'(0));
        check("rst_err", WIDTH'(error_out), WIDTH'(0));
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_no_start", WIDTH'(busy_out | valid_out), WIDTH'(0));

        // small known inverses
        start(WIDTH'(3), WIDTH'(7), WIDTH'(5), 1'b0);
        check("a3m7_busy", WIDTH'(busy_out), WIDTH'(1));
        wait_done("a3m7", 1);
        start(WIDTH'(1), WIDTH'(7), WIDTH'(1), 1'b0);
        wait_done("a1m7", 1);
        start(WIDTH'(2), WIDTH'(7), WIDTH'(4), 1'b0);
        wait_done("a2m7", 1);
        if (RED) start(WIDTH'(10), WIDTH'(7), WIDTH'(5), 1'b0);
        else     start(WIDTH'(10), WIDTH'(7), '0, 1'b1);
        wait_done("a10m7", 1);

        // error cases
        start(WIDTH'(6), WIDTH'(9), '0, 1'b1);
        wait_done("a6m9", 1);
        @(negedge clk_in);
        check("a6m9_err_sticky", WIDTH'(error_out), WIDTH'(1));
        start(WIDTH'(0), WIDTH'(7), '0, 1'b1);
        wait_done("a0m7", 1);
        start(WIDTH'(3), WIDTH'(8), '0, 1'b1);
        wait_done("a3m8", 1);
        start(WIDTH'(3), WIDTH'(1), '0, 1'b1);
        wait_done("a3m1", 1);

        // full-width vector
        if (RED) start(BIG_A, BIG_M, BIG_B, 1'b0);
        else     start(BIG_A, BIG_M, '0, 1'b1);
        wait_done("big", 1);

        // second strobe while busy is ignored
        start(WIDTH'(3), WIDTH'(7), WIDTH'(5), 1'b0);
        check("ignore_busy", WIDTH'(busy_out), WIDTH'(1));
        a_in     = WIDTH'(2);
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        wait_done("ignore", 2);
        pulses = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (valid_out === 1'b1) pulses++;
        end
        check("ignore_extra_pulses", WIDTH'(pulses), WIDTH'(0));

        // reset mid-run abandons the operation
        @(negedge clk_in);
        a_in     = WIDTH'(3);
        base     = BIG_M;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("midrst_busy_before", WIDTH'(busy_out), WIDTH'(1));
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        check("midrst_b", b_out, '0);
        check("midrst_busy", WIDTH'(busy_out), WIDTH'(0));
        check("midrst_valid", WIDTH'(valid_out), WIDTH'(0));
        check("midrst_err", WIDTH'(error_out), WIDTH'(0));
        pulses = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (valid_out === 1'b1 || busy_out === 1'b1) pulses++;
        end
        check("midrst_quiet", WIDTH'(pulses), WIDTH'(0));
        start(WIDTH'(2), WIDTH'(7), WIDTH'(4), 1'b0);
        wait_done("after_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
